// File: rtl/led_s2p.sv
`timescale 1ns/1ps
// led_s2p: serial-to-parallel receiver for the LED shift-chain protocol.
// Oversamples led_clk/led_sout/led_clrn/LED_PEN in the clk domain, shifts
// bits right on each led_clk rise and latches the word on each LED_PEN rise.
// There is no handshake: valid is a one-cycle strobe with no back-pressure,
// and par_out/frame_err are meaningful on the cycle valid is high.
module led_s2p #(
    parameter int DATA_BITS   = 16,
    parameter int INVERT      = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               led_clk,
    input  logic                               led_sout,
    input  logic                               led_clrn,
    input  logic                               LED_PEN,
    output logic [DATA_BITS-1:0]               par_out,
    output logic                               valid,
    output logic                               frame_err,
    output logic [$clog2(DATA_BITS+1)-1:0]     bit_cnt
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_BITS);
    localparam logic [DATA_BITS-1:0] INV_MASK = (INVERT != 0) ? '1 : '0;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] sout_sync;
    logic [SYNC_STAGES-1:0] clrn_sync;
    logic [SYNC_STAGES-1:0] pen_sync;
    logic                   clk_d;
    logic                   pen_d;

    logic                   clk_s;
    logic                   sin;
    logic                   clrn_s;
    logic                   pen_s;
    logic                   clk_rise;
    logic                   pen_rise;

    logic [DATA_BITS-1:0]   sr;
    logic                   ovf;

    logic [DATA_BITS-1:0]   sr_next;
    logic [CW-1:0]          cnt_next;
    logic                   ovf_next;

    // Synchroniser chains plus one extra flop on led_clk/LED_PEN for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= '0;
            sout_sync <= '0;
            clrn_sync <= '0;
            pen_sync  <= '0;
            clk_d     <= 1'b0;
            pen_d     <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], led_clk};
            sout_sync <= {sout_sync[SYNC_STAGES-2:0], led_sout};
            clrn_sync <= {clrn_sync[SYNC_STAGES-2:0], led_clrn};
            pen_sync  <= {pen_sync[SYNC_STAGES-2:0], LED_PEN};
            clk_d     <= clk_sync[SYNC_STAGES-1];
            pen_d     <= pen_sync[SYNC_STAGES-1];
        end
    end

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign sin      = sout_sync[SYNC_STAGES-1];
    assign clrn_s   = clrn_sync[SYNC_STAGES-1];
    assign pen_s    = pen_sync[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_d;
    assign pen_rise = pen_s & ~pen_d;

    // Post-shift view of the frame so a latch on the same cycle sees the new bit
    always_comb begin
        sr_next  = sr;
        cnt_next = bit_cnt;
        ovf_next = ovf;
        if (clk_rise) begin
            sr_next = {sin, sr[DATA_BITS-1:1]};
            if (bit_cnt == FULL) begin
                ovf_next = 1'b1;
            end else begin
                cnt_next = bit_cnt + CW'(1);
            end
        end
    end

    // Shift register, bit counter, latch and clear; clear overrides any edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr        <= '0;
            ovf       <= 1'b0;
            bit_cnt   <= '0;
            par_out   <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (!clrn_s) begin
                sr      <= '0;
                bit_cnt <= '0;
                ovf     <= 1'b0;
            end else begin
                sr <= sr_next;
                if (pen_rise) begin
                    par_out   <= sr_next ^ INV_MASK;
                    valid     <= 1'b1;
                    frame_err <= (cnt_next != FULL) || ovf_next;
                    bit_cnt   <= '0;
                    ovf       <= 1'b0;
                end else begin
                    bit_cnt <= cnt_next;
                    ovf     <= ovf_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_s2p.sv
`timescale 1ns/1ps
// tb_led_s2p: directed and randomized frames for led_s2p, checked against a
// bit-history model of the LED chain.
module tb_led_s2p;

    localparam int N    = 16;
    localparam int SYNC = 2;

    logic          clk;
    logic          rst;
    logic          led_clk;
    logic          led_sout;
    logic          led_clrn;
    logic          LED_PEN;
    logic [N-1:0]  par_out;
    logic          valid;
    logic          frame_err;
    logic [4:0]    bit_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int vcount = 0;

    // Model: every wire bit since last clear/reset, and the current frame length
    bit            hist[$];
    int            frame_cnt = 0;
    logic [N-1:0]  exp_q[$];

    led_s2p #(.DATA_BITS(N), .INVERT(1), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst       (rst),
        .led_clk   (led_clk),
        .led_sout  (led_sout),
        .led_clrn  (led_clrn),
        .LED_PEN   (LED_PEN),
        .par_out   (par_out),
        .valid     (valid),
        .frame_err (frame_err),
        .bit_cnt   (bit_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global valid pulse counter
    always @(negedge clk) if (valid === 1'b1) vcount++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input bit b);
        hist.push_back(b);
        frame_cnt++;
    endtask

    task automatic model_clear();
        hist.delete();
        frame_cnt = 0;
    endtask

    // Word on the chain = last N wire bits (oldest at bit 0), zeros if fewer, inverted
    function automatic logic [N-1:0] model_word();
        logic [N-1:0] w;
        int idx;
        for (int i = 0; i < N; i++) begin
            idx = hist.size() - N + i;
            w[i] = (idx >= 0) ? hist[idx] : 1'b0;
        end
        return ~w;
    endfunction

    function automatic int model_cnt();
        return (frame_cnt > N) ? N : frame_cnt;
    endfunction

    task automatic send_bit(input bit b);
        @(negedge clk);
        led_sout = b;
        repeat (2) @(negedge clk);
        led_clk = 1'b1;
        model_push(b);
        repeat (4) @(negedge clk);
        led_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Wire bit i is ~led[i % N] (active-low LEDs)
    task automatic send_frame(input logic [N-1:0] led, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(~led[i % N]);
    endtask

    // Raise LED_PEN (optionally with a coincident led_clk rise) and check the latch
    task automatic latch(input string tag, input bit with_clk);
        int hits;
        int at_k;
        logic [N-1:0] got_w;
        logic got_e;
        logic exp_e;
        logic [N-1:0] exp_w;
        hits = 0; at_k = 0; got_w = '0; got_e = 1'b0;
        @(negedge clk);
        if (with_clk) begin
            led_clk = 1'b1;
            model_push(led_sout);
        end
        LED_PEN = 1'b1;
        exp_q.push_back(model_word());
        exp_e = (frame_cnt != N);
        frame_cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                hits++;
                at_k  = k;
                got_w = par_out;
                got_e = frame_err;
            end
        end
        exp_w = exp_q.pop_front();
        check({tag, "_valid_count"}, hits, 1);
        check({tag, "_valid_latency"}, at_k, SYNC + 1);
        check({tag, "_par_out"}, got_w, exp_w);
        check({tag, "_frame_err"}, got_e, exp_e);
        LED_PEN = 1'b0;
        led_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int v0;
        logic [N-1:0] led;
        int nb;

        // Reset with random serial activity, then idle
        rst = 1'b0; led_clk = 1'b0; led_sout = 1'b0; led_clrn = 1'b1; LED_PEN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            led_clk  = 1'($urandom_range(0, 1));
            led_sout = 1'($urandom_range(0, 1));
            led_clrn = 1'($urandom_range(0, 1));
            LED_PEN  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        led_clk = 1'b0; led_sout = 1'b0; led_clrn = 1'b1; LED_PEN = 1'b0;
        check("rst_par_out", par_out, 0);
        check("rst_bit_cnt", bit_cnt, 0);
        check("rst_valid", valid, 0);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        v0 = vcount;
        repeat (20) @(negedge clk);
        check("idle_no_valid", vcount, v0);
        check("idle_par_out", par_out, 0);
        check("idle_bit_cnt", bit_cnt, 0);

        // Nominal frame
        send_frame(16'h002A, N);
        check("nom_bit_cnt", bit_cnt, model_cnt());
        latch("nominal", 1'b0);
        check("nom_cnt_cleared", bit_cnt, 0);

        // Short frame
        send_frame(16'h1234, 15);
        check("short_bit_cnt", bit_cnt, 15);
        latch("short", 1'b0);

        // Long frame
        send_frame(16'hBEEF, 17);
        check("long_bit_cnt", bit_cnt, N);
        latch("long", 1'b0);

        // Clear after 8 bits, then a full 0xFFFF frame
        send_frame(16'h00FF, 8);
        check("pre_clr_bit_cnt", bit_cnt, 8);
        @(negedge clk);
        v0 = vcount;
        led_clrn = 1'b0;
        repeat (5) @(negedge clk);
        led_clrn = 1'b1;
        model_clear();
        repeat (4) @(negedge clk);
        check("clr_bit_cnt", bit_cnt, 0);
        check("clr_no_valid", vcount, v0);
        send_frame(16'hFFFF, N);
        latch("after_clear", 1'b0);

        // Coincident shift and latch on the 16th bit
        led = 16'h8001;
        send_frame(led, N - 1);
        @(negedge clk);
        led_sout = ~led[N-1];
        repeat (2) @(negedge clk);
        latch("coincident", 1'b1);

        // Reset asserted mid-frame
        send_frame(16'h5A5A, 10);
        check("mid_bit_cnt", bit_cnt, 10);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_bit_cnt", bit_cnt, 0);
        check("mid_rst_par_out", par_out, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(16'h003F, 6);
        check("post_rst_bit_cnt", bit_cnt, 6);
        latch("post_reset", 1'b0);

        // Randomized frames of varying length
        for (int f = 0; f < 8; f++) begin
            led = N'($urandom);
            nb  = $urandom_range(N - 2, N + 2);
            send_frame(led, nb);
            check("rand_bit_cnt", bit_cnt, model_cnt());
            latch("random", 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_s2p.md
# led_s2p

Serial-to-parallel receiver for the board LED shift-chain protocol. It monitors the serial lines driven by the SPIO parallel-to-serial shifter (`led_clk`, `led_sout`, `led_clrn`, `LED_PEN`) from the system clock domain and reconstructs the 16-bit LED word. It is used as an on-chip loopback checker and as a behavioural stand-in for the external shift-register chain, so benches and self-test logic can read back what SPIO displayed.

## Interface
Parameters:
- `DATA_BITS`, 16, frame length in bits and width of `par_out`.
- `INVERT`, 1, when 1, received bits are inverted before output, because the LEDs are active-low on the wire.
- `SYNC_STAGES`, 2, number of synchroniser flops on each serial input; legal values are 2 or more.

Ports:
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `led_clk` input 1: serial shift clock. Data is taken on its rising edge.
- `led_sout` input 1: serial data.
- `led_clrn` input 1: active-low chain clear.
- `LED_PEN` input 1: latch enable. A rising edge transfers the shifted word to the output.
- `par_out` output `DATA_BITS`: the last latched word.
- `valid` output 1: one-cycle pulse when `par_out` updates.
- `frame_err` output 1: one-cycle pulse coincident with `valid` when the latched frame length was not exactly `DATA_BITS`.
- `bit_cnt` output `$clog2(DATA_BITS+1)`: number of bits shifted since the last latch or clear. It saturates at `DATA_BITS`.

## Operation
- **Input synchronisers.** Each of `led_clk`, `led_sout`, `led_clrn` and `LED_PEN` passes through `SYNC_STAGES` flops. One further flop on `led_clk` and `LED_PEN` provides rising-edge detection: `clk_rise` and `pen_rise`.
- **Shift.** On `clk_rise`, `sr <= {sin, sr[DATA_BITS-1:1]}`, where `sin` is the synchronised `led_sout`. This is a right shift. After `DATA_BITS` shifts, the first bit received sits at `sr[0]`, so `par_out[i]` corresponds to the i-th bit on the wire. With SPIO this recovers `LED[i]` directly, with no reversal.
- **Bit count.** On each shift, `bit_cnt` increments until it reaches `DATA_BITS` and then holds. A shift while `bit_cnt == DATA_BITS` sets the internal sticky flag `ovf`.
- **Latch.** On `pen_rise`:
  - `par_out <= sr ^ {DATA_BITS{INVERT}}`.
  - `valid` pulses.
  - `frame_err` pulses if `bit_cnt != DATA_BITS` or `ovf` is set.
  - `bit_cnt` clears to 0 and `ovf` clears to 0.
  - `sr` is not cleared.
- **Clear.** While the synchronised `led_clrn` is 0:
  - `sr`, `bit_cnt` and `ovf` are held at 0.
  - `par_out` holds its last value.
  - `clk_rise` and `pen_rise` are ignored; no `valid` is generated.
- **Reset values.** `par_out = 0`, `valid = 0`, `frame_err = 0`, `bit_cnt = 0`. `sr`, `ovf` and all synchroniser and edge flops also reset to 0, so no spurious edge is detected after reset.

## Timing
- Latency from an input edge to its effect is `SYNC_STAGES+1` clk rising edges. This applies to a `led_clk` rise (the shift) and to a `LED_PEN` rise (`par_out`, `valid` and `frame_err` all update on the same edge).
- `led_sout` passes through the same synchroniser depth as `led_clk`. It must therefore be stable from one clk period before to one clk period after each `led_clk` rise.
- `led_clk` high time and low time must each be at least `SYNC_STAGES+1` clk periods. Faster toggling is out of spec, and bits may be lost.
- **Shift and latch on the same cycle.** The shift takes effect first, and the latched word includes the new bit. `bit_cnt` counts that bit before the length check, then clears.
- **Clear with a simultaneous edge.** Clear takes priority; no shift and no `valid` occur.
- **Reset asserted mid-frame.** All state clears immediately, asynchronously. After release, the remaining bits of the interrupted frame are counted as a new short frame, and the next latch pulses `frame_err`.
- **Back-to-back frames.** Valid as long as `LED_PEN` returns low for at least `SYNC_STAGES+1` periods between latches.
- **`LED_PEN` held high.** Produces only one latch.

## Test plan
- **Reset.** Hold `rst = 0` with random serial inputs, then release. Required: `par_out = 0x0000`, `bit_cnt = 0`, and no `valid` for 20 cycles while the inputs stay idle.
- **Nominal frame.** Set `INVERT = 1`. Shift `~LED[0]` … `~LED[15]` for `LED = 0x002A`, then pulse `LED_PEN`. Required: `par_out = 0x002A`, a single-cycle `valid` exactly `SYNC_STAGES+1` cycles after the `LED_PEN` rise, and `frame_err = 0`.
- **Short and long frames.** Shift 15 bits and latch: `valid` and `frame_err` both pulse. Then shift 17 bits and latch: `frame_err` pulses and `bit_cnt` reads 16 before the latch.
- **Clear.** After 8 bits, pull `led_clrn` low for 5 cycles, then send a full frame of `0xFFFF` and latch. Required: `par_out = 0xFFFF`, no error, and no `valid` during the clear.
- **Coincident shift and latch.** `led_clk` rises on the same clk edge as `LED_PEN` at the 16th bit, with data `0x8001`. Required: `par_out = 0x8001` and `frame_err = 0`.
- **Reset mid-frame.** Assert `rst` after 10 bits. Required: `bit_cnt = 0` immediately. Then send 6 more bits and latch: `frame_err = 1`.
